// File: rtl/doorlock_ctrl.sv
// rtl/doorlock_ctrl.sv - keypad code entry, unlock/fail/lockout sequencing and display mode
module doorlock_ctrl #(
   parameter int                  DIGITS         = 4,
   parameter logic [4*DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
   parameter int                  OPEN_CYCLES    = 50_000_000,
   parameter int                  FAIL_CYCLES    = 25_000_000,
   parameter int                  LOCKOUT_CYCLES = 250_000_000,
   parameter int                  ENTRY_TIMEOUT  = 100_000_000,
   parameter int                  MAX_FAILS      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       key_enter,
   input  logic       key_clear,
   output logic [1:0] disp_mode,
   output logic       unlock,
   output logic       alarm,
   output logic [1:0] fail_cnt
);

   localparam int BW    = 4 * DIGITS;
   localparam int CW    = $clog2(DIGITS + 1);
   localparam int MAX_A = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
   localparam int MAX_B = (LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT;
   localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int TW    = $clog2(MAX_T) + 1;

   localparam logic [TW-1:0] T_OPEN  = TW'(OPEN_CYCLES);
   localparam logic [TW-1:0] T_FAIL  = TW'(FAIL_CYCLES);
   localparam logic [TW-1:0] T_LOCK  = TW'(LOCKOUT_CYCLES);
   localparam logic [TW-1:0] T_ENTRY = TW'(ENTRY_TIMEOUT);
   localparam logic [CW-1:0] FULL    = CW'(DIGITS);
   localparam logic [1:0]    FAIL_LIM = 2'(MAX_FAILS);

   localparam logic [1:0] DISP_BLANK = 2'b00;
   localparam logic [1:0] DISP_OPEN  = 2'b01;
   localparam logic [1:0] DISP_CLOSE = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKOUT
   } state_t;

   state_t          state, state_nx;
   logic [BW-1:0]   entry_buf, buf_nx;
   logic [CW-1:0]   count, count_nx;
   logic [BW-1:0]   code, code_nx;
   logic [TW-1:0]   timer, timer_nx;
   logic [1:0]      fail_nx;
   logic [1:0]      disp_nx;
   logic            unlock_nx, alarm_nx;

   logic            digit_ok;
   logic [BW-1:0]   shifted;
   logic            timer_last;
   logic [TW-1:0]   timer_dec;
   logic [1:0]      fail_inc;
   logic            match;

   // Only a lone digit strobe (no clear/enter in the same cycle) with a BCD value counts
   assign digit_ok   = key_valid && !key_enter && !key_clear && (key_digit <= 4'd9);
   assign shifted    = (entry_buf << 4) | BW'(key_digit);
   assign timer_last = (timer == TW'(1));
   assign timer_dec  = timer - TW'(1);
   assign fail_inc   = (fail_cnt == FAIL_LIM) ? fail_cnt : fail_cnt + 2'd1;
   assign match      = (count == FULL) && (entry_buf == code);

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_nx = state;
      buf_nx   = entry_buf;
      count_nx = count;
      code_nx  = code;
      timer_nx = timer;
      fail_nx  = fail_cnt;

      case (state)
         S_IDLE: begin
            if (digit_ok) begin
               buf_nx   = shifted;
               count_nx = CW'(1);
               timer_nx = T_ENTRY;
               state_nx = S_ENTRY;
            end
         end
         S_ENTRY: begin
            if (key_clear) begin
               buf_nx   = '0;
               count_nx = '0;
               state_nx = S_IDLE;
            end else if (key_enter) begin
               state_nx = S_CHECK;
            end else if (digit_ok && (count < FULL)) begin
               buf_nx   = shifted;
               count_nx = count + CW'(1);
               timer_nx = T_ENTRY;
            end else if (timer_last) begin
               buf_nx   = '0;
               count_nx = '0;
               state_nx = S_IDLE;
            end else begin
               timer_nx = timer_dec;
            end
         end
         S_CHECK: begin
            buf_nx   = '0;
            count_nx = '0;
            if (match) begin
               fail_nx  = 2'd0;
               timer_nx = T_OPEN;
               state_nx = S_OPEN;
            end else begin
               fail_nx = fail_inc;
               if (fail_inc == FAIL_LIM) begin
                  timer_nx = T_LOCK;
                  state_nx = S_LOCKOUT;
               end else begin
                  timer_nx = T_FAIL;
                  state_nx = S_FAIL;
               end
            end
         end
         S_OPEN: begin
            timer_nx = timer_dec;
            if (key_clear) begin
               buf_nx   = '0;
               count_nx = '0;
            end else if (key_enter) begin
               buf_nx   = '0;
               count_nx = '0;
               if (count == FULL) begin
                  code_nx  = entry_buf;
                  state_nx = S_IDLE;
               end
            end else if (digit_ok && (count < FULL)) begin
               buf_nx   = shifted;
               count_nx = count + CW'(1);
            end
            // Window expiry: leave with an empty buffer so IDLE starts clean
            if ((state_nx == S_OPEN) && timer_last) begin
               buf_nx   = '0;
               count_nx = '0;
               state_nx = S_IDLE;
            end
         end
         S_FAIL: begin
            if (timer_last) state_nx = S_IDLE;
            else            timer_nx = timer_dec;
         end
         S_LOCKOUT: begin
            if (timer_last) begin
               fail_nx  = 2'd0;
               state_nx = S_IDLE;
            end else begin
               timer_nx = timer_dec;
            end
         end
         default: begin
            buf_nx   = '0;
            count_nx = '0;
            state_nx = S_IDLE;
         end
      endcase

      disp_nx   = DISP_CLOSE;
      unlock_nx = 1'b0;
      alarm_nx  = 1'b0;
      case (state_nx)
         S_OPEN:    begin disp_nx = DISP_OPEN; unlock_nx = 1'b1; end
         S_FAIL:    disp_nx = DISP_BLANK;
         S_LOCKOUT: begin disp_nx = DISP_BLANK; alarm_nx = 1'b1; end
         default:   disp_nx = DISP_CLOSE;
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         entry_buf <= '0;
         count     <= '0;
         code      <= DEFAULT_CODE;
         timer     <= '0;
         fail_cnt  <= 2'd0;
         disp_mode <= DISP_CLOSE;
         unlock    <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         state     <= state_nx;
         entry_buf <= buf_nx;
         count     <= count_nx;
         code      <= code_nx;
         timer     <= timer_nx;
         fail_cnt  <= fail_nx;
         disp_mode <= disp_nx;
         unlock    <= unlock_nx;
         alarm     <= alarm_nx;
      end
   end

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb/tb_doorlock_ctrl.sv - directed checks of doorlock_ctrl with short timing parameters
module tb_doorlock_ctrl;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       key_enter;
   logic       key_clear;
   logic [1:0] disp_mode;
   logic       unlock;
   logic       alarm;
   logic [1:0] fail_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n;

   doorlock_ctrl #(
      .DIGITS(4), .DEFAULT_CODE(16'h1234), .OPEN_CYCLES(8), .FAIL_CYCLES(4),
      .LOCKOUT_CYCLES(16), .ENTRY_TIMEOUT(20), .MAX_FAILS(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
      .key_enter(key_enter), .key_clear(key_clear), .disp_mode(disp_mode),
      .unlock(unlock), .alarm(alarm), .fail_cnt(fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_digit(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic press_enter();
      key_enter = 1'b1;
      tick();
      key_enter = 1'b0;
   endtask

   task automatic enter_code(input logic [15:0] c);
      for (int i = 3; i >= 0; i--) press_digit(c[4*i +: 4]);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (disp_mode != 2'b10 && k < 60) begin
         k++;
         tick();
      end
      check("reach_idle", disp_mode, 2);
   endtask

   initial begin
      rst_n = 1'b0; key_valid = 1'b0; key_digit = 4'd0; key_enter = 1'b0; key_clear = 1'b0;
      tick(); tick();
      check("rst_disp", disp_mode, 2);
      check("rst_unlock", unlock, 0);
      check("rst_alarm", alarm, 0);
      check("rst_fail", fail_cnt, 0);
      rst_n = 1'b1;
      tick();
      check("idle_disp", disp_mode, 2);

      // correct code
      enter_code(16'h1234);
      press_enter();
      check("check_disp", disp_mode, 2);
      check("check_unlock", unlock, 0);
      tick();
      check("open_disp", disp_mode, 1);
      check("open_unlock", unlock, 1);
      n = 0;
      while (unlock && n < 40) begin n++; tick(); end
      check("open_len", n, 8);
      check("post_open_disp", disp_mode, 2);
      check("post_open_fail", fail_cnt, 0);

      // two wrong attempts then lockout
      for (int a = 1; a <= 2; a++) begin
         enter_code(16'h1235);
         press_enter();
         tick();
         check("wrong_disp", disp_mode, 0);
         check("wrong_fail_cnt", fail_cnt, a);
         n = 0;
         while (disp_mode == 2'b00 && n < 40) begin n++; tick(); end
         check("fail_len", n, 4);
         check("post_fail_disp", disp_mode, 2);
      end
      enter_code(16'h1235);
      press_enter();
      tick();
      check("lock_alarm", alarm, 1);
      check("lock_disp", disp_mode, 0);
      check("lock_fail_cnt", fail_cnt, 3);
      n = 0;
      while (alarm && n < 40) begin
         n++;
         key_valid = 1'b1;
         key_digit = 4'd1;
         key_enter = (n % 2 == 0);
         tick();
      end
      key_valid = 1'b0;
      key_enter = 1'b0;
      check("lock_len", n, 16);
      check("post_lock_fail", fail_cnt, 0);
      check("post_lock_disp", disp_mode, 2);
      press_enter();
      tick();
      check("lock_keys_ignored", disp_mode, 2);

      // short entry, long entry, non-BCD digit
      press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
      press_enter();
      tick();
      check("short_disp", disp_mode, 0);
      check("short_fail", fail_cnt, 1);
      wait_idle();
      enter_code(16'h1234);
      press_digit(4'd9);
      press_enter();
      tick();
      check("long_unlock", unlock, 1);
      check("long_fail", fail_cnt, 0);
      wait_idle();
      press_digit(4'd1); press_digit(4'd2); press_digit(4'd3);
      press_digit(4'hA);
      press_digit(4'd4);
      press_enter();
      tick();
      check("hex_digit_ignored", unlock, 1);
      wait_idle();

      // clear beats enter
      enter_code(16'h1234);
      key_clear = 1'b1;
      key_enter = 1'b1;
      tick();
      key_clear = 1'b0;
      key_enter = 1'b0;
      tick();
      check("clr_ent_disp", disp_mode, 2);
      check("clr_ent_unlock", unlock, 0);
      press_enter();
      tick();
      check("clr_buf_empty", disp_mode, 2);

      // inactivity timeout boundary: 19 idle cycles keeps entry, 20 discards it
      press_digit(4'd1); press_digit(4'd2);
      repeat (19) tick();
      press_digit(4'd3); press_digit(4'd4);
      press_enter();
      tick();
      check("idle19_unlock", unlock, 1);
      wait_idle();
      press_digit(4'd1); press_digit(4'd2);
      repeat (20) tick();
      press_digit(4'd3); press_digit(4'd4);
      press_enter();
      tick();
      check("idle20_disp", disp_mode, 0);
      check("idle20_fail", fail_cnt, 1);
      wait_idle();

      // code change while open
      enter_code(16'h1234);
      press_enter();
      tick();
      check("cc_open", unlock, 1);
      check("cc_fail", fail_cnt, 0);
      press_digit(4'd5);
      press_enter();
      check("partial_enter_stays", unlock, 1);
      enter_code(16'h9876);
      press_enter();
      check("cc_exit_unlock", unlock, 0);
      check("cc_exit_disp", disp_mode, 2);
      tick();
      check("cc_idle", disp_mode, 2);
      enter_code(16'h1234);
      press_enter();
      tick();
      check("old_code_rejected", disp_mode, 0);
      check("old_code_fail", fail_cnt, 1);
      wait_idle();
      enter_code(16'h9876);
      press_enter();
      tick();
      check("new_code_open", unlock, 1);
      check("new_code_fail", fail_cnt, 0);

      // asynchronous reset mid-OPEN and mid-ENTRY
      #2 rst_n = 1'b0;
      #1;
      check("rst_open_unlock", unlock, 0);
      check("rst_open_disp", disp_mode, 2);
      rst_n = 1'b1;
      tick();
      press_digit(4'd9); press_digit(4'd8);
      #2 rst_n = 1'b0;
      #1;
      check("rst_entry_disp", disp_mode, 2);
      check("rst_entry_unlock", unlock, 0);
      check("rst_entry_fail", fail_cnt, 0);
      rst_n = 1'b1;
      tick();
      enter_code(16'h9876);
      press_enter();
      tick();
      check("rst_code_9876", disp_mode, 0);
      wait_idle();
      enter_code(16'h1234);
      press_enter();
      tick();
      check("rst_code_1234", unlock, 1);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
